// File: rtl/video_timing_pkg.sv
// Video timing mode definitions: mode indices, per-mode timing struct and the mode table.
package video_timing_pkg;

  localparam int unsigned TW        = 12;
  localparam int unsigned NUM_MODES = 3;

  typedef enum logic [1:0] {
    MODE_640X480  = 2'd0,
    MODE_800X600  = 2'd1,
    MODE_1280X720 = 2'd2,
    MODE_RSVD     = 2'd3
  } mode_e;

  typedef struct packed {
    logic [TW-1:0] h_active;
    logic [TW-1:0] h_front;
    logic [TW-1:0] h_sync;
    logic [TW-1:0] h_back;
    logic [TW-1:0] v_active;
    logic [TW-1:0] v_front;
    logic [TW-1:0] v_sync;
    logic [TW-1:0] v_back;
    logic          h_pos;
    logic          v_pos;
  } mode_timing_t;

  localparam mode_timing_t MODE_TABLE [NUM_MODES] = '{
    '{12'd640,  12'd16,  12'd96,  12'd48,  12'd480, 12'd10, 12'd2, 12'd33, 1'b0, 1'b0},
    '{12'd800,  12'd40,  12'd128, 12'd88,  12'd600, 12'd1,  12'd4, 12'd23, 1'b1, 1'b1},
    '{12'd1280, 12'd110, 12'd40,  12'd220, 12'd720, 12'd5,  12'd5, 12'd20, 1'b1, 1'b1}
  };

  // Reserved index falls back to mode 0 so the counters always see a legal geometry.
  function automatic mode_timing_t timing_of(input logic [1:0] m);
    case (m)
      2'd1:    return MODE_TABLE[1];
      2'd2:    return MODE_TABLE[2];
      default: return MODE_TABLE[0];
    endcase
  endfunction

  function automatic logic [TW-1:0] h_total(input mode_timing_t t);
    return t.h_active + t.h_front + t.h_sync + t.h_back;
  endfunction

  function automatic logic [TW-1:0] v_total(input mode_timing_t t);
    return t.v_active + t.v_front + t.v_sync + t.v_back;
  endfunction

endpackage

// File: rtl/delay_pipe.sv
// Generic fixed-depth register pipeline with synchronous reset to a supplied value.
module delay_pipe #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] rst_val,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  if (DEPTH == 0) begin : g_wire
    logic unused_pipe;
    assign unused_pipe = ^{clk, rst, rst_val};
    assign dout        = din;
  end else begin : g_pipe
    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];

    always_comb begin
      stage_d[0] = din;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        stage_d[i] = stage_q[i-1];
      end
    end

    always_ff @(posedge clk) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        stage_q[i] <= rst ? rst_val : stage_d[i];
      end
    end

    assign dout = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/video_timing_gen.sv
// Multi-mode video timing generator: h/v counters, frame-boundary mode switching,
// registered sync/active/pulse decode followed by an equal-delay alignment pipe.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int unsigned CW         = 12,
  parameter int unsigned PIPE_DELAY = 2,
  parameter int unsigned RESET_MODE = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    mode_sel,
  input  logic          mode_apply,
  output logic          mode_busy,
  output logic [1:0]    cur_mode,
  output logic [CW-1:0] pixel_x,
  output logic [CW-1:0] pixel_y,
  output logic          hsync,
  output logic          vsync,
  output logic          active,
  output logic          line_start,
  output logic          frame_start,
  output logic [15:0]   frame_count
);

  localparam logic [1:0]      RST_MODE   = 2'(RESET_MODE);
  localparam mode_timing_t    RST_TIMING = timing_of(RST_MODE);
  localparam int unsigned     OW         = 2 + 1 + 16 + 2*CW + 5;
  localparam logic [OW-1:0]   FLUSH      = {RST_MODE, 1'b0, 16'd0, {(2*CW){1'b0}},
                                            ~RST_TIMING.h_pos, ~RST_TIMING.v_pos, 3'b000};

  logic [CW-1:0] h_q, h_d, v_q, v_d;
  logic [1:0]    cur_mode_q, cur_mode_d, pend_mode_q, pend_mode_d;
  logic          busy_q, busy_d;
  logic [15:0]   frame_count_q, frame_count_d;
  logic [OW-1:0] out_q, out_d, out_pipe;

  mode_timing_t  tm;
  logic          h_last, v_last, h_in_sync, v_in_sync;
  logic [TW-1:0] hs_start, vs_start;

  // Counter advance; a pending mode takes effect only on the last pixel of a frame.
  always_comb begin
    tm            = timing_of(cur_mode_q);
    h_last        = (h_q == CW'(h_total(tm) - TW'(1)));
    v_last        = (v_q == CW'(v_total(tm) - TW'(1)));
    h_d           = h_q + CW'(1);
    v_d           = v_q;
    cur_mode_d    = cur_mode_q;
    pend_mode_d   = pend_mode_q;
    busy_d        = busy_q;
    frame_count_d = frame_count_q;
    if (h_last) begin
      h_d = '0;
      if (v_last) begin
        v_d           = '0;
        frame_count_d = frame_count_q + 16'd1;
        if (busy_q) begin
          cur_mode_d = pend_mode_q;
          busy_d     = 1'b0;
        end
      end else begin
        v_d = v_q + CW'(1);
      end
    end
    // Applied after the switch so a request on the boundary cycle targets the next frame.
    if (mode_apply && (mode_sel != 2'(MODE_RSVD))) begin
      pend_mode_d = mode_sel;
      busy_d      = 1'b1;
    end
  end

  always_comb begin
    hs_start  = tm.h_active + tm.h_front;
    vs_start  = tm.v_active + tm.v_front;
    h_in_sync = (h_q >= CW'(hs_start)) && (h_q < CW'(hs_start + tm.h_sync));
    v_in_sync = (v_q >= CW'(vs_start)) && (v_q < CW'(vs_start + tm.v_sync));
    out_d     = {cur_mode_q, busy_q, frame_count_q, h_q, v_q,
                 h_in_sync ~^ tm.h_pos,
                 v_in_sync ~^ tm.v_pos,
                 (h_q < CW'(tm.h_active)) && (v_q < CW'(tm.v_active)),
                 (h_q == '0),
                 (h_q == '0) && (v_q == '0)};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_q           <= '0;
      v_q           <= '0;
      cur_mode_q    <= RST_MODE;
      pend_mode_q   <= RST_MODE;
      busy_q        <= 1'b0;
      frame_count_q <= '0;
      out_q         <= FLUSH;
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      cur_mode_q    <= cur_mode_d;
      pend_mode_q   <= pend_mode_d;
      busy_q        <= busy_d;
      frame_count_q <= frame_count_d;
      out_q         <= out_d;
    end
  end

  delay_pipe #(
    .WIDTH (OW),
    .DEPTH (PIPE_DELAY)
  ) u_align (
    .clk     (clk),
    .rst     (rst),
    .rst_val (FLUSH),
    .din     (out_q),
    .dout    (out_pipe)
  );

  assign {cur_mode, mode_busy, frame_count, pixel_x, pixel_y,
          hsync, vsync, active, line_start, frame_start} = out_pipe;

endmodule
